uart_tx_fifo_gen: RTL and testbench



---
 rtl/uart_tx_fifo_gen.sv | 205 ++++++++++++++++++++
 tb/tb_uart_tx_fifo_gen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_gen.sv
// uart_tx_fifo_gen: transmit FIFO feeding a 5-8 bit UART frame engine paced by xmit_pulse.
// Defining UART_TX_BREAK_EN adds the send_break port and line-break hold logic.
module uart_tx_fifo_gen #(
    parameter int FIFO_DEPTH = 16,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          xmit_pulse,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic [1:0]    data_len,
    input  logic          parity_en,
    input  logic          odd_n_even,
    input  logic          stop2,
`ifdef UART_TX_BREAK_EN
    input  logic          send_break,
`endif
    output logic          tx,
    output logic          txrdy,
    output logic          tx_empty,
    output logic [CW-1:0] fifo_count,
    output logic          overflow
);

    // state  | meaning
    // IDLE   | line idle (or held low during a break), waiting for data
    // START  | start bit on the line
    // DATA   | data bit bit_cnt on the line
    // PARITY | parity bit on the line
    // STOP1  | first stop bit on the line
    // STOP2  | second stop bit on the line
    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP1, ST_STOP2
    } state_t;

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    state_t        state_q, state_d;
    logic          tx_q, tx_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [1:0]    len_q, len_d;
    logic          par_en_q, par_en_d;
    logic          parity_q, parity_d;
    logic          stop2_q, stop2_d;

    logic          fifo_empty, fifo_full, wr_accept, pop_allowed, do_pop, frame_end;
    logic [7:0]    head_word, data_mask;
    logic          head_parity;
    logic [2:0]    last_bit;

    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == CW'(FIFO_DEPTH));
    assign wr_accept   = wr_en && !fifo_full;
`ifdef UART_TX_BREAK_EN
    assign pop_allowed = xmit_pulse && !fifo_empty && !send_break;
`else
    assign pop_allowed = xmit_pulse && !fifo_empty;
`endif

    assign head_word   = mem_q[rd_ptr_q];
    assign data_mask   = 8'hFF >> (2'd3 - data_len);
    assign head_parity = (^(head_word & data_mask)) ^ odd_n_even;
    assign last_bit    = {1'b0, len_q} + 3'd4;

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        len_d     = len_q;
        par_en_d  = par_en_q;
        parity_d  = parity_q;
        stop2_d   = stop2_q;
        do_pop    = 1'b0;
        frame_end = 1'b0;
        if (xmit_pulse) begin
            case (state_q)
                ST_IDLE: begin
`ifdef UART_TX_BREAK_EN
                    // leaving a break costs one full high bit before the next frame
                    if (send_break)  tx_d = 1'b0;
                    else if (!tx_q)  tx_d = 1'b1;
                    else             do_pop = pop_allowed;
`else
                    do_pop = pop_allowed;
`endif
                end
                ST_START: begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = 3'd0;
                    state_d   = ST_DATA;
                end
                ST_DATA: begin
                    if (bit_cnt_q == last_bit) begin
                        if (par_en_q) begin
                            tx_d    = parity_q;
                            state_d = ST_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = ST_STOP1;
                        end
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                ST_PARITY: begin
                    tx_d    = 1'b1;
                    state_d = ST_STOP1;
                end
                ST_STOP1: begin
                    if (stop2_q) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP2;
                    end else begin
                        frame_end = 1'b1;
                    end
                end
                ST_STOP2: frame_end = 1'b1;
                default: begin
                    tx_d    = 1'b1;
                    state_d = ST_IDLE;
                end
            endcase
        end
        if (frame_end) begin
            state_d = ST_IDLE;
`ifdef UART_TX_BREAK_EN
            tx_d    = !send_break;
`endif
            do_pop  = pop_allowed;
        end
        // pop loads the head word and freezes the frame format until the next pop
        if (do_pop) begin
            state_d  = ST_START;
            tx_d     = 1'b0;
            shift_d  = head_word;
            len_d    = data_len;
            par_en_d = parity_en;
            parity_d = head_parity;
            stop2_d  = stop2;
        end
    end

    always_comb begin
        wr_ptr_d   = wr_accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        overflow_d = wr_en && fifo_full;
        case ({wr_accept, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_accept) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= ST_IDLE;
            tx_q       <= 1'b1;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            len_q      <= '0;
            par_en_q   <= 1'b0;
            parity_q   <= 1'b0;
            stop2_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            tx_q       <= tx_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            len_q      <= len_d;
            par_en_q   <= par_en_d;
            parity_q   <= parity_d;
            stop2_q    <= stop2_d;
        end
    end

    assign tx         = tx_q;
    assign txrdy      = !fifo_full;
    assign tx_empty   = fifo_empty && (state_q == ST_IDLE);
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo_gen.sv
// Directed bench for uart_tx_fifo_gen: frame-format vector table plus FIFO/reset/break sequences.
module tb_uart_tx_fifo_gen;
    localparam int DEPTH = 16;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset, xmit_pulse, wr_en, parity_en, odd_n_even, stop2;
    logic [7:0]    wr_data;
    logic [1:0]    data_len;
`ifdef UART_TX_BREAK_EN
    logic          send_break;
`endif
    logic          tx, txrdy, tx_empty, overflow;
    logic [CW-1:0] fifo_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_fifo_gen #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .xmit_pulse(xmit_pulse), .wr_en(wr_en),
        .wr_data(wr_data), .data_len(data_len), .parity_en(parity_en),
        .odd_n_even(odd_n_even), .stop2(stop2),
`ifdef UART_TX_BREAK_EN
        .send_break(send_break),
`endif
        .tx(tx), .txrdy(txrdy), .tx_empty(tx_empty),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  len;
        logic        par_en;
        logic        odd;
        logic        st2;
        int          nbits;
        logic [11:0] bits;   // first line bit at position nbits-1
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse();
        xmit_pulse = 1'b1;
        tick();
        xmit_pulse = 1'b0;
        tick();
        tick();
    endtask

    task automatic write(input logic [7:0] d);
        wr_data = d;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
    endtask

    function automatic logic f81(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        return 1'b1;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 10, 12'b000101001011};
        vecs[1] = '{8'h35, 2'd2, 1'b1, 1'b0, 1'b1, 11, 12'b001010110011};
        vecs[2] = '{8'h13, 2'd0, 1'b1, 1'b1, 1'b0,  8, 12'b000001100101};
        vecs[3] = '{8'h2A, 2'd1, 1'b1, 1'b0, 1'b0,  9, 12'b000001010111};
        vecs[4] = '{8'hFF, 2'd0, 1'b0, 1'b0, 1'b1,  8, 12'b000001111111};
        vecs[5] = '{8'h00, 2'd3, 1'b1, 1'b1, 1'b0, 11, 12'b000000000011};

        reset = 1'b1; xmit_pulse = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
        data_len = 2'd3; parity_en = 1'b0; odd_n_even = 1'b0; stop2 = 1'b0;
`ifdef UART_TX_BREAK_EN
        send_break = 1'b0;
`endif
        tick(); tick();
        reset = 1'b0;
        chk("rst_tx", tx, 1);
        chk("rst_txrdy", txrdy, 1);
        chk("rst_tx_empty", tx_empty, 1);
        chk("rst_count", fifo_count, 0);
        chk("rst_overflow", overflow, 0);

        // frame format table; config inputs are scrambled after the pop to prove latching
        for (int i = 0; i < 6; i++) begin
            data_len = vecs[i].len; parity_en = vecs[i].par_en;
            odd_n_even = vecs[i].odd; stop2 = vecs[i].st2;
            write(vecs[i].data);
            chk($sformatf("v%0d_count", i), fifo_count, 1);
            chk($sformatf("v%0d_not_empty", i), tx_empty, 0);
            for (int b = 0; b < vecs[i].nbits; b++) begin
                pulse();
                chk($sformatf("v%0d_bit%0d", i, b), tx, vecs[i].bits[vecs[i].nbits-1-b]);
                if (b == 0) begin
                    data_len = ~data_len; parity_en = ~parity_en;
                    odd_n_even = ~odd_n_even; stop2 = ~stop2;
                end
            end
            pulse();
            chk($sformatf("v%0d_idle_empty", i), tx_empty, 1);
            chk($sformatf("v%0d_idle_tx", i), tx, 1);
        end

        // back-to-back 8N1 frames
        data_len = 2'd3; parity_en = 1'b0; odd_n_even = 1'b0; stop2 = 1'b0;
        write(8'h00);
        write(8'hFF);
        chk("b2b_count", fifo_count, 2);
        for (int b = 0; b < 20; b++) begin
            pulse();
            chk($sformatf("b2b_bit%0d", b), tx, (b < 10) ? f81(8'h00, b) : f81(8'hFF, b - 10));
        end
        pulse();
        chk("b2b_idle_empty", tx_empty, 1);

        // overflow: fill, drop one, then drop one coincident with a pop
        for (int i = 0; i < 16; i++) write(8'h10 + 8'(i));
        chk("ovf_count_full", fifo_count, 16);
        chk("ovf_txrdy_low", txrdy, 0);
        chk("ovf_no_pulse_yet", overflow, 0);
        write(8'hEE);
        chk("ovf_pulse", overflow, 1);
        chk("ovf_count_held", fifo_count, 16);
        tick();
        chk("ovf_pulse_one_cycle", overflow, 0);
        wr_data = 8'hEF; wr_en = 1'b1; xmit_pulse = 1'b1;
        tick();
        wr_en = 1'b0; xmit_pulse = 1'b0;
        chk("ovf_pop_pulse", overflow, 1);
        chk("ovf_pop_count", fifo_count, 15);
        chk("ovf_pop_start", tx, 0);
        tick(); tick();
        for (int k = 0; k < 16; k++) begin
            for (int b = 0; b < 10; b++) begin
                if (!(k == 0 && b == 0)) begin
                    pulse();
                    chk($sformatf("ovf_f%0d_bit%0d", k, b), tx, f81(8'h10 + 8'(k), b));
                end
            end
        end
        pulse();
        chk("ovf_drained_empty", tx_empty, 1);
        chk("ovf_drained_count", fifo_count, 0);

        // reset during DATA bit 3, coincident with a pulse that would send a 0
        write(8'h08);
        write(8'h3C);
        for (int b = 0; b < 5; b++) pulse();
        chk("rmid_bit3", tx, 1);
        reset = 1'b1; xmit_pulse = 1'b1;
        tick();
        reset = 1'b0; xmit_pulse = 1'b0;
        chk("rmid_tx", tx, 1);
        chk("rmid_count", fifo_count, 0);
        chk("rmid_tx_empty", tx_empty, 1);
        chk("rmid_txrdy", txrdy, 1);
        for (int b = 0; b < 12; b++) begin
            pulse();
            chk($sformatf("rmid_quiet%0d", b), tx, 1);
        end
        chk("rmid_still_empty", tx_empty, 1);

`ifdef UART_TX_BREAK_EN
        write(8'h0F);
        write(8'hF0);
        for (int b = 0; b < 10; b++) begin
            pulse();
            chk($sformatf("brk_f0_bit%0d", b), tx, f81(8'h0F, b));
            if (b == 2) send_break = 1'b1;
        end
        for (int p = 0; p < 3; p++) begin
            pulse();
            chk($sformatf("brk_hold_tx%0d", p), tx, 0);
            chk($sformatf("brk_hold_count%0d", p), fifo_count, 1);
        end
        send_break = 1'b0;
        pulse();
        chk("brk_release_high", tx, 1);
        chk("brk_release_count", fifo_count, 1);
        for (int b = 0; b < 10; b++) begin
            pulse();
            chk($sformatf("brk_f1_bit%0d", b), tx, f81(8'hF0, b));
        end
        pulse();
        chk("brk_idle_empty", tx_empty, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
